// File: rtl/riscv_pc_gen.sv
// Program-counter generator: selects the next fetch address, reports misaligned
// targets, handles trap redirects and counts completed fetch handshakes.
module riscv_pc_gen #(
  parameter int unsigned             WORD_LENGTH  = 32,
  parameter int unsigned             PC_OFFSET    = 4,
  parameter logic [WORD_LENGTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned             CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic [1:0]             pc_sel,
  input  logic [WORD_LENGTH-1:0] imm_j_sext,
  input  logic [WORD_LENGTH-1:0] imm_b_sext,
  input  logic [WORD_LENGTH-1:0] jalr_target,
  input  logic                   br_flag,
  input  logic                   stall,
  input  logic                   trap_req,
  input  logic [WORD_LENGTH-1:0] trap_vector,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [WORD_LENGTH-1:0] pc_out,
  output logic [WORD_LENGTH-1:0] pc_plus4,
  output logic                   misalign_err,
  output logic [WORD_LENGTH-1:0] misalign_addr,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_J_TARGET = 2'd1;
  localparam logic [1:0] PC_B_TARGET = 2'd2;
  localparam logic [1:0] PC_JALR     = 2'd3;

  localparam logic [WORD_LENGTH-1:0] OFFSET = WORD_LENGTH'(PC_OFFSET);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t state;

  logic [WORD_LENGTH-1:0] target;
  logic                   handshake;
  logic                   target_bad;

  // Offsets arrive sign-extended; the add wraps modulo 2^WORD_LENGTH.
  function automatic logic [WORD_LENGTH-1:0] add_offset(
    input logic        [WORD_LENGTH-1:0] base,
    input logic signed [WORD_LENGTH-1:0] off
  );
    return base + $unsigned(off);
  endfunction

  function automatic logic word_misaligned(input logic [WORD_LENGTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [WORD_LENGTH-1:0] word_align(input logic [WORD_LENGTH-1:0] addr);
    return {addr[WORD_LENGTH-1:2], 2'b00};
  endfunction

  assign pc_plus4    = add_offset(pc_out, OFFSET);
  assign fetch_valid = (state == RUN) && !stall;
  assign handshake   = fetch_valid && fetch_ready;

  always_comb begin
    target = pc_plus4;
    case (pc_sel)
      PC_J_TARGET: target = add_offset(pc_out, imm_j_sext);
      PC_B_TARGET: target = br_flag ? add_offset(pc_out, imm_b_sext) : pc_plus4;
      PC_JALR:     target = {jalr_target[WORD_LENGTH-1:1], 1'b0};
      default:     target = pc_plus4;
    endcase
  end

  assign target_bad = word_misaligned(target);

  // Trap overrides every state, including BOOT, stall and a pending handshake.
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state         <= BOOT;
      pc_out        <= RESET_VECTOR;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
      fetch_count   <= '0;
    end else if (trap_req) begin
      state        <= RUN;
      pc_out       <= word_align(trap_vector);
      misalign_err <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (handshake) begin
            if (target_bad) begin
              state         <= HALT;
              misalign_err  <= 1'b1;
              misalign_addr <= target;
            end else begin
              pc_out      <= target;
              fetch_count <= fetch_count + CNT_WIDTH'(1);
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_pc_gen.sv
// Randomized scoreboard bench for riscv_pc_gen: a rule-level model predicts the
// post-edge outputs, a monitor pops and compares them each cycle.
module tb_riscv_pc_gen;

  localparam logic [1:0] S_PLUS4 = 2'd0;
  localparam logic [1:0] S_J     = 2'd1;
  localparam logic [1:0] S_B     = 2'd2;
  localparam logic [1:0] S_JALR  = 2'd3;

  logic        clk = 1'b0;
  logic        x_reset;
  logic [1:0]  pc_sel;
  logic [31:0] imm_j_sext, imm_b_sext, jalr_target, trap_vector;
  logic        br_flag, stall, trap_req, fetch_ready;
  logic        fetch_valid, misalign_err;
  logic [31:0] pc_out, pc_plus4, misalign_addr, fetch_count;

  riscv_pc_gen dut (
    .clk(clk), .x_reset(x_reset), .pc_sel(pc_sel),
    .imm_j_sext(imm_j_sext), .imm_b_sext(imm_b_sext), .jalr_target(jalr_target),
    .br_flag(br_flag), .stall(stall), .trap_req(trap_req), .trap_vector(trap_vector),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .misalign_err(misalign_err), .misalign_addr(misalign_addr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic [31:0] cnt;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state, kept as plain facts rather than an encoded FSM
  logic [31:0] m_pc, m_cnt, m_addr;
  logic        m_err, m_booting, m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 0; m_addr = 0; m_err = 0; m_booting = 1; m_halted = 0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and predict the next edge.
  task automatic step(input logic [1:0] sel, input logic [31:0] ij, input logic [31:0] ib,
                      input logic [31:0] jt, input logic br, input logic st,
                      input logic tr, input logic [31:0] tv, input logic rdy);
    logic        fv_now, hs;
    logic [31:0] tgt;
    exp_t        e;
    pc_sel = sel; imm_j_sext = ij; imm_b_sext = ib; jalr_target = jt; br_flag = br;
    stall = st; trap_req = tr; trap_vector = tv; fetch_ready = rdy;
    fv_now = !m_booting && !m_halted && !st;
    hs = fv_now && rdy;
    if (tr) begin
      m_pc = tv - (tv % 4);
      m_booting = 0; m_halted = 0; m_err = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (hs) begin
      if (sel == S_J)                 tgt = m_pc + ij;
      else if (sel == S_B && br)      tgt = m_pc + ib;
      else if (sel == S_JALR)         tgt = jt - (jt % 2);
      else                            tgt = m_pc + 32'd4;
      if (tgt % 4 != 0) begin
        m_halted = 1; m_err = 1; m_addr = tgt;
      end else begin
        m_pc = tgt; m_cnt = m_cnt + 1;
      end
    end
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.fv = !m_booting && !m_halted && !st;
    e.cnt = m_cnt; e.err = m_err; e.addr = m_addr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] sel, input logic [31:0] ij, input logic [31:0] ib,
                     input logic [31:0] jt, input logic br, input logic st,
                     input logic tr, input logic [31:0] tv, input logic rdy);
    @(negedge clk);
    step(sel, ij, ib, jt, br, st, tr, tv, rdy);
  endtask

  task automatic plus4(input logic st, input logic rdy);
    cyc(S_PLUS4, 0, 0, 0, 0, st, 0, 0, rdy);
  endtask

  task automatic trap_to(input logic [31:0] tv);
    cyc(S_PLUS4, 0, 0, 0, 0, 0, 1, tv, 1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pc_out",        pc_out,               e.pc);
      check("pc_plus4",      pc_plus4,             e.pc4);
      check("fetch_valid",   {31'd0, fetch_valid}, {31'd0, e.fv});
      check("fetch_count",   fetch_count,          e.cnt);
      check("misalign_err",  {31'd0, misalign_err},{31'd0, e.err});
      check("misalign_addr", misalign_addr,        e.addr);
    end
  end

  initial begin
    logic [31:0] ij, ib, jt, tv;
    x_reset = 1'b1; pc_sel = S_PLUS4; imm_j_sext = 0; imm_b_sext = 0; jalr_target = 0;
    br_flag = 0; stall = 0; trap_req = 0; trap_vector = 0; fetch_ready = 1;
    #1 x_reset = 1'b0;
    #1;
    check("rst_pc",    pc_out,               32'h0);
    check("rst_fv",    {31'd0, fetch_valid}, 32'd0);
    check("rst_cnt",   fetch_count,          32'd0);
    check("rst_err",   {31'd0, misalign_err},32'd0);
    check("rst_addr",  misalign_addr,        32'd0);
    model_reset();
    repeat (2) @(negedge clk);

    // Boot then sequential fetch
    x_reset = 1'b1;
    step(S_PLUS4, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) plus4(0, 1);

    // Branch taken with negative offset, then not taken
    trap_to(32'h100);
    cyc(S_B, 0, 32'hFFFF_FFF0, 0, 1, 0, 0, 0, 1);
    trap_to(32'h100);
    cyc(S_B, 0, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 1);

    // Misaligned JALR halts; trap recovers
    trap_to(32'h200);
    cyc(S_JALR, 0, 0, 32'h303, 0, 0, 0, 0, 1);
    plus4(0, 1);
    plus4(0, 1);
    trap_to(32'h83);

    // Stall holds regardless of ready; trap wins over stall
    repeat (3) plus4(1, 1);
    cyc(S_PLUS4, 0, 0, 0, 0, 1, 1, 32'h440, 1);

    // Wrap at the top of the address space, then ready low
    trap_to(32'hFFFF_FFFC);
    plus4(0, 1);
    repeat (2) plus4(0, 0);
    plus4(0, 1);

    // Trap during BOOT
    @(negedge clk);
    x_reset = 1'b0; #1 model_reset();
    @(negedge clk);
    x_reset = 1'b1;
    step(S_PLUS4, 0, 0, 0, 0, 0, 1, 32'h1000, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ij = $urandom; ib = $urandom; jt = $urandom; tv = $urandom;
      if ($urandom_range(7) != 0) ij[1:0] = 2'b00;
      if ($urandom_range(7) != 0) ib[1:0] = 2'b00;
      if ($urandom_range(7) != 0) jt[1]   = 1'b0;
      cyc(2'($urandom_range(3)), ij, ib, jt, 1'($urandom_range(1)),
          $urandom_range(3) == 0, $urandom_range(11) == 0, tv, $urandom_range(3) != 0);
    end

    // Asynchronous reset between edges at pc=0x40
    trap_to(32'h40);
    plus4(1, 1);
    @(posedge clk);
    #2 x_reset = 1'b0;
    #1;
    check("async_rst_pc",   pc_out,               32'h0);
    check("async_rst_cnt",  fetch_count,          32'd0);
    check("async_rst_fv",   {31'd0, fetch_valid}, 32'd0);
    check("async_rst_addr", misalign_addr,        32'd0);
    model_reset();
    @(negedge clk);
    x_reset = 1'b1;
    step(S_PLUS4, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) plus4(0, 1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
